rom_image_spi_writer: RTL and testbench

- Sits directly downstream of the file-to-ROM loading stage. It consumes its word stream through the loader control lines: reset, load, 16-bit data, ack and load_received.
- Writes each accepted 16-bit instruction word into the external SPI SRAM that backs the Hack ROM. Transfers are single-word SPI WRITE sequences at auto-incrementing addresses.
- Reports per-word completion back upstream with a one-cycle ack pulse.

---
 rtl/rom_image_spi_writer.sv | 107 ++++++++++
 tb/tb_rom_image_spi_writer.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_image_spi_writer.sv
// rom_image_spi_writer: writes each loader word to the SPI SRAM behind the Hack ROM
// as a single-word WRITE (02h, 24-bit byte address, 16-bit data) at auto-incrementing addresses.
module rom_image_spi_writer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15,
   parameter int SCK_DIV    = 2,
   parameter int CS_GAP     = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rom_loader_reset,
   input  logic                  rom_loader_load,
   input  logic [DATA_WIDTH-1:0] rom_loader_data,
   output logic                  rom_loader_load_received,
   output logic                  rom_loader_ack,
   output logic                  spi_cs_n,
   output logic                  spi_sck,
   output logic                  spi_mosi,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] words_written
);
   localparam int CW = $clog2(2*SCK_DIV + CS_GAP + 1);
   localparam logic [CW-1:0] BIT_LAST = CW'(2*SCK_DIV - 1);
   localparam logic [CW-1:0] SCK_RISE = CW'(SCK_DIV - 1);
   localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);

   typedef enum logic [2:0] {IDLE, ACCEPT, SHIFT, CS_END, GAP, ACK} state_t;

   state_t                state_q;
   logic [47:0]           sr_q;
   logic [CW-1:0]         cnt_q;
   logic [5:0]            bit_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  cs_n_q, sck_q, mosi_q, lr_q, ack_q;
   logic [47:0]           frame_d;

   // byte address is the word address shifted left, zero-extended to 24 bits
   assign frame_d = {8'h02, {(23-ADDR_WIDTH){1'b0}}, addr_q, 1'b0, rom_loader_data};

   always_ff @(posedge clk) begin
      if (reset || rom_loader_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         bit_q   <= '0;
         cs_n_q  <= 1'b1;
         sck_q   <= 1'b0;
         mosi_q  <= 1'b0;
         lr_q    <= 1'b0;
         ack_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (rom_loader_load) begin
               sr_q    <= frame_d;
               mosi_q  <= frame_d[47];
               cs_n_q  <= 1'b0;
               sck_q   <= 1'b0;
               lr_q    <= 1'b1;
               state_q <= ACCEPT;
            end
            ACCEPT: begin
               lr_q    <= 1'b0;
               cnt_q   <= '0;
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: if (cnt_q == BIT_LAST) begin
               cnt_q <= '0;
               sck_q <= 1'b0;
               if (bit_q == 6'd47) state_q <= CS_END;
               else begin
                  bit_q  <= bit_q + 1'b1;
                  sr_q   <= sr_q << 1;
                  mosi_q <= sr_q[46];
               end
            end else begin
               cnt_q <= cnt_q + 1'b1;
               sck_q <= cnt_q >= SCK_RISE;
            end
            CS_END: begin
               cs_n_q  <= 1'b1;
               mosi_q  <= 1'b0;
               cnt_q   <= '0;
               state_q <= GAP;
            end
            GAP: if (cnt_q == GAP_LAST) begin
               ack_q   <= 1'b1;
               addr_q  <= addr_q + 1'b1;
               state_q <= ACK;
            end else cnt_q <= cnt_q + 1'b1;
            ACK: begin
               ack_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rom_loader_load_received = lr_q;
   assign rom_loader_ack           = ack_q;
   assign spi_cs_n                 = cs_n_q;
   assign spi_sck                  = sck_q;
   assign spi_mosi                 = mosi_q;
   assign busy                     = state_q != IDLE;
   assign words_written            = addr_q;
endmodule

// File: tb/tb_rom_image_spi_writer.sv
// tb_rom_image_spi_writer: scoreboard bench; a 15-bit and a 2-bit address instance share stimulus,
// SPI frames are decoded from the pins and compared against frames queued at load_received.
module tb_rom_image_spi_writer;
   logic        clk = 0, reset = 1, rl_reset = 0, load = 0;
   logic [15:0] data = 16'h0;
   logic        lr0, ack0, cs0, sck0, mosi0, busy0;
   logic        lr1, ack1, cs1, sck1, mosi1, busy1;
   logic [14:0] ww0;
   logic [1:0]  ww1;
   int          checks = 0, errors = 0, cyc = 0, nwords = 0;
   int          aborted = 0, ack_cnt = 0, lr_cnt = 0;
   logic [95:0] exp_q[$];

   rom_image_spi_writer dut0 (
      .clk(clk), .reset(reset), .rom_loader_reset(rl_reset), .rom_loader_load(load),
      .rom_loader_data(data), .rom_loader_load_received(lr0), .rom_loader_ack(ack0),
      .spi_cs_n(cs0), .spi_sck(sck0), .spi_mosi(mosi0), .busy(busy0), .words_written(ww0));

   rom_image_spi_writer #(.ADDR_WIDTH(2)) dut1 (
      .clk(clk), .reset(reset), .rom_loader_reset(rl_reset), .rom_loader_load(load),
      .rom_loader_data(data), .rom_loader_load_received(lr1), .rom_loader_ack(ack1),
      .spi_cs_n(cs1), .spi_sck(sck1), .spi_mosi(mosi1), .busy(busy1), .words_written(ww1));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [47:0] frame(input logic [15:0] d, input int a);
      return {8'h02, 24'(a * 2), d};
   endfunction

   // SPI decoder and protocol monitor for both instances
   wire  [1:0]  cs_v = {cs1, cs0}, sck_v = {sck1, sck0}, mosi_v = {mosi1, mosi0};
   logic [1:0]  cs_p = 2'b11, sck_p = 2'b00, mosi_p = 2'b00;
   logic [47:0] sh[2];
   int          nb[2], hi[2];
   bit          done[2];
   logic        lr_p = 0, ack_p = 0;
   logic [95:0] e;

   always @(negedge clk) begin
      if (reset) begin
         for (int k = 0; k < 2; k++) begin
            nb[k] = 0;
            hi[k] = 100;
            done[k] = 0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (!cs_v[k] && sck_v[k] && !sck_p[k]) begin
               sh[k] = {sh[k][46:0], mosi_v[k]};
               nb[k]++;
            end
            checks++;
            if (sck_v[k] && sck_p[k] && mosi_v[k] !== mosi_p[k]) begin
               errors++;
               $display("FAIL mosi_stable dut%0d: mosi changed to %b while sck high, required %b", k, mosi_v[k], mosi_p[k]);
            end
            checks++;
            if (cs_v[k] && sck_v[k]) begin
               errors++;
               $display("FAIL sck_idle dut%0d: sck=%b with cs_n=1, required 0", k, sck_v[k]);
            end
            if (cs_v[k] && !cs_p[k]) begin
               if (nb[k] == 48) done[k] = 1;
               else aborted++;
               nb[k] = 0;
            end
            if (!cs_v[k] && cs_p[k]) begin
               checks++;
               if (hi[k] < 2) begin
                  errors++;
                  $display("FAIL cs_gap dut%0d: cs_n high %0d cycles, required >= 2", k, hi[k]);
               end
               hi[k] = 0;
            end
            if (cs_v[k]) hi[k]++;
         end
         if (done[0] || done[1]) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL frame: got %h/%h with no frame expected", sh[0], sh[1]);
            end else begin
               e = exp_q.pop_front();
               if (done[0] !== done[1] || sh[0] !== e[95:48] || sh[1] !== e[47:0]) begin
                  errors++;
                  $display("FAIL frame: got %h/%h, required %h/%h", sh[0], sh[1], e[95:48], e[47:0]);
               end
            end
            done[0] = 0;
            done[1] = 0;
         end
         checks++;
         if ((lr0 && ack0) || (lr0 && ack_p) || (ack0 && lr_p)) begin
            errors++;
            $display("FAIL pulse_excl: lr=%b ack=%b prev lr=%b ack=%b, required not overlapping/adjacent", lr0, ack0, lr_p, ack_p);
         end
         if (lr0) lr_cnt++;
         if (ack0) ack_cnt++;
      end
      cs_p = cs_v;
      sck_p = sck_v;
      mosi_p = mosi_v;
      lr_p = lr0;
      ack_p = ack0;
   end

   // one word: present it, queue its frame at load_received, then wait for and time the ack
   task automatic send(input logic [15:0] d, input logic [15:0] dn, input bit keep, output int lat);
      bit got = 0;
      int lc;
      lat = -1;
      data = d;
      load = 1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (lr0) begin
            got = 1;
            lat = i;
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL lr_timeout: no load_received for %h, required within 400 cycles", d);
         return;
      end
      lc = cyc;
      exp_q.push_back({frame(d, nwords % 32768), frame(d, nwords % 4)});
      @(posedge clk);
      #1;
      if (keep) data = dn;
      else load = 0;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (ack0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL ack_timeout: no ack for %h, required within 400 cycles", d);
         return;
      end
      checks++;
      if (cyc - lc !== 196) begin
         errors++;
         $display("FAIL ack_latency: %0d cycles after load_received, required 196", cyc - lc);
      end
      nwords++;
      @(negedge clk);
      checks++;
      if (ww0 !== 15'(nwords % 32768) || ww1 !== 2'(nwords % 4)) begin
         errors++;
         $display("FAIL words_written: got %0d/%0d, required %0d/%0d", ww0, ww1, nwords % 32768, nwords % 4);
      end
   endtask

   task automatic loader_reset();
      @(posedge clk);
      #1;
      rl_reset = 1;
      load = 0;
      @(posedge clk);
      #1;
      rl_reset = 0;
      nwords = 0;
      @(negedge clk);
      checks++;
      if ({cs0, sck0, busy0, ww0, ww1} !== {1'b1, 2'b00, 15'd0, 2'd0}) begin
         errors++;
         $display("FAIL loader_reset: cs_n=%b sck=%b busy=%b ww=%0d/%0d, required 1 0 0 0/0", cs0, sck0, busy0, ww0, ww1);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({cs0, sck0, mosi0, lr0, ack0, busy0, ww0} !== {1'b1, 5'b0, 15'd0}) begin
         errors++;
         $display("FAIL reset_vals: cs_n=%b sck=%b mosi=%b lr=%b ack=%b busy=%b ww=%0d, required 1 0 0 0 0 0 0", cs0, sck0, mosi0, lr0, ack0, busy0, ww0);
      end
      checks++;
      if ({cs1, busy1, ww1} !== {1'b1, 1'b0, 2'd0}) begin
         errors++;
         $display("FAIL reset_vals1: cs_n=%b busy=%b ww=%0d, required 1 0 0", cs1, busy1, ww1);
      end
      @(posedge clk);
      #1;
      reset = 0;
   endtask

   task automatic test_first();
      int lat;
      @(posedge clk);
      #1;
      rl_reset = 1;
      load = 1;
      data = 16'hEC10;
      @(posedge clk);
      #1;
      rl_reset = 0;
      @(negedge clk);
      checks++;
      if (lr0 !== 1'b0 || busy0 !== 1'b0) begin
         errors++;
         $display("FAIL reset_over_load: lr=%b busy=%b, required 0 0", lr0, busy0);
      end
      send(16'hEC10, 16'h0000, 0, lat);
      checks++;
      if (lat !== 0) begin
         errors++;
         $display("FAIL lr_latency: load_received after %0d extra cycles, required 0", lat);
      end
   endtask

   task automatic test_three();
      int lat;
      loader_reset();
      send(16'h0001, 16'h0002, 1, lat);
      send(16'h0002, 16'hFFFF, 1, lat);
      send(16'hFFFF, 16'h0000, 0, lat);
      repeat (3) @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || ww0 !== 15'd3 || lr0 !== 1'b0) begin
         errors++;
         $display("FAIL three_end: busy=%b ww=%0d lr=%b, required 0 3 0", busy0, ww0, lr0);
      end
   endtask

   task automatic test_held();
      int lat, l0, a0;
      loader_reset();
      l0 = lr_cnt;
      a0 = ack_cnt;
      send(16'h1111, 16'h2222, 1, lat);
      send(16'h2222, 16'h3333, 1, lat);
      send(16'h3333, 16'h4444, 1, lat);
      checks++;
      if (lat !== 0) begin
         errors++;
         $display("FAIL held_resample: next word taken after %0d extra cycles, required 0", lat);
      end
      send(16'h4444, 16'h0000, 0, lat);
      repeat (5) @(negedge clk);
      checks++;
      if (lr_cnt - l0 !== 4 || ack_cnt - a0 !== 4) begin
         errors++;
         $display("FAIL held_pulses: %0d load_received / %0d acks, required 4/4", lr_cnt - l0, ack_cnt - a0);
      end
   endtask

   task automatic test_abort();
      int lat, a0, ab0;
      bit got = 0;
      loader_reset();
      send(16'hA001, 16'hA002, 1, lat);
      send(16'hA002, 16'hA003, 1, lat);
      send(16'hA003, 16'hA004, 1, lat);
      send(16'hA004, 16'hA005, 1, lat);
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (lr0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL abort_lr: word 5 not accepted, required load_received");
      end
      repeat (81) @(negedge clk);
      a0 = ack_cnt;
      ab0 = aborted;
      @(posedge clk);
      #1;
      rl_reset = 1;
      load = 0;
      @(posedge clk);
      #1;
      rl_reset = 0;
      nwords = 0;
      @(negedge clk);
      checks++;
      if ({cs0, sck0, busy0, ww0, ww1} !== {1'b1, 2'b00, 15'd0, 2'd0}) begin
         errors++;
         $display("FAIL abort_state: cs_n=%b sck=%b busy=%b ww=%0d/%0d, required 1 0 0 0/0", cs0, sck0, busy0, ww0, ww1);
      end
      repeat (300) @(negedge clk);
      checks++;
      if (ack_cnt !== a0 || aborted - ab0 !== 2) begin
         errors++;
         $display("FAIL abort_ack: %0d acks, %0d aborted frames, required 0 and 2", ack_cnt - a0, aborted - ab0);
      end
      send(16'h5A5A, 16'h0000, 0, lat);
   endtask

   task automatic test_gap_reset();
      int a0;
      bit got = 0;
      data = 16'hBEEF;
      load = 1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (lr0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL gap_lr: no load_received, required one");
      end
      exp_q.push_back({frame(16'hBEEF, nwords % 32768), frame(16'hBEEF, nwords % 4)});
      @(posedge clk);
      #1;
      load = 0;
      got = 0;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if (cs0) got = 1;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL gap_timeout: cs_n never rose, required within 400 cycles");
      end
      a0 = ack_cnt;
      @(posedge clk);
      #1;
      reset = 1;
      @(posedge clk);
      #1;
      reset = 0;
      nwords = 0;
      @(negedge clk);
      checks++;
      if ({cs0, sck0, mosi0, lr0, ack0, busy0, ww0} !== {1'b1, 5'b0, 15'd0}) begin
         errors++;
         $display("FAIL gap_reset: cs_n=%b sck=%b mosi=%b lr=%b ack=%b busy=%b ww=%0d, required 1 0 0 0 0 0 0", cs0, sck0, mosi0, lr0, ack0, busy0, ww0);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (ack_cnt !== a0) begin
         errors++;
         $display("FAIL gap_ack: %0d acks after reset, required 0", ack_cnt - a0);
      end
   endtask

   task automatic test_wrap();
      int lat;
      loader_reset();
      for (int i = 0; i < 5; i++) send(16'hC000 + 16'(i), 16'hC001 + 16'(i), i < 4, lat);
      checks++;
      if (ww1 !== 2'd1 || ww0 !== 15'd5) begin
         errors++;
         $display("FAIL wrap: ww=%0d/%0d, required 5/1", ww0, ww1);
      end
   endtask

   initial begin
      test_reset();
      test_first();
      test_three();
      test_held();
      test_abort();
      test_gap_reset();
      test_wrap();
      repeat (5) @(negedge clk);
      checks++;
      if (exp_q.size() !== 0) begin
         errors++;
         $display("FAIL frames_left: %0d expected frames never seen, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
